// File: rtl/rs_dec_chien_forney_mc.sv
// Serial Chien search + Forney error evaluator with channel tag, runtime length and stall pipeline.
// Optional macro RS_SEARCH_FAIL_CHECK_EN adds the per-codeword root-count failure flag.
module rs_dec_chien_forney_mc #(
    parameter int BITSPERSYMBOL = 8,
    parameter int CHECK         = 32,
    parameter int IRRPOL        = 285,
    parameter int N             = 255,
    parameter int GENSTART      = 4,
    parameter int CHANNEL       = 1,
    parameter int VARN          = 0,
    localparam int M            = BITSPERSYMBOL,
    localparam int T            = CHECK / 2,
    localparam int CW           = (CHANNEL > 1) ? $clog2(CHANNEL) : 1,
    localparam int ECW          = $clog2(T + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bm_in_valid,
    output logic                 bm_in_ready,
    input  logic [(T+1)*M-1:0]   bm_in_error_locator,
    input  logic [T*M-1:0]       bm_in_error_evaluator,
    input  logic [ECW-1:0]       bm_in_error_count,
    input  logic [M-1:0]         bm_in_numn,
    input  logic [CW-1:0]        bm_in_channel,
    output logic                 sch_out_valid,
    input  logic                 sch_out_ready,
    output logic                 sch_out_sop,
    output logic                 sch_out_eop,
    output logic                 sch_out_error,
    output logic [M-1:0]         sch_out_error_magnitude,
    output logic [ECW-1:0]       sch_out_error_count,
    output logic [CW-1:0]        sch_out_channel,
    output logic                 sch_out_fail,
    output logic [1:0]           o_dbg_state
);
    localparam int Q   = (T > GENSTART) ? T : GENSTART;
    localparam int P   = M + Q;
    localparam int PCW = $clog2(P + 1);
    localparam logic [M:0]   IRR   = (M+1)'(IRRPOL);
    localparam logic [M-1:0] ONE   = M'(1);
    localparam logic [M-1:0] ALPHA = M'(2);

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            r = {r[M-2:0], 1'b0} ^ (r[M-1] ? IRR[M-1:0] : '0);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // a^(2^M-2); maps 0 to 0, which zeroes the magnitude when Lodd==0
    function automatic logic [M-1:0] gf_inv(input logic [M-1:0] a);
        logic [M-1:0] r;
        r = ONE;
        for (int i = 0; i < M; i++) begin
            r = gf_mul(r, r);
            if (i < M - 1) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] r;
        r = ONE;
        for (int i = 0; i < e; i++) r = gf_mul(r, ALPHA);
        return r;
    endfunction

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PREP = 2'd1, S_SEARCH = 2'd2} state_t;
    state_t r_state, w_next;

    logic [M-1:0]   r_lam [0:T];
    logic [M-1:0]   r_omg [0:T-1];
    logic [M-1:0]   r_p, r_b, r_acc, r_e, r_n, r_k;
    logic [PCW-1:0] r_pc;
    logic [ECW-1:0] r_ecnt;
    logic [CW-1:0]  r_ch;

    logic           r_s1_valid, r_s1_sop, r_s1_eop;
    logic [M-1:0]   r_s1_l, r_s1_lodd, r_s1_w, r_s1_p;
    logic [ECW-1:0] r_s1_ecnt;
    logic [CW-1:0]  r_s1_ch;

    logic           r_o_valid, r_o_sop, r_o_eop, r_o_err;
    logic [M-1:0]   r_o_mag;
    logic [ECW-1:0] r_o_ecnt;
    logic [CW-1:0]  r_o_ch;

    logic           w_en, w_acc, w_last, w_err;
    logic [M-1:0]   w_n, w_sq, w_l, w_lodd, w_w, w_mag, w_p_step;
    logic [M-1:0]   w_lam_step [0:T];
    logic [M-1:0]   w_omg_step [0:T-1];

    // One enable stalls the search step and both pipeline stages together
    assign w_en        = !r_o_valid | sch_out_ready;
    assign bm_in_ready = (r_state == S_IDLE) & ~rst;
    assign w_acc       = bm_in_valid & bm_in_ready;
    assign w_last      = (r_k == r_n - ONE);
    assign w_sq        = gf_mul(gf_mul(r_acc, r_acc), r_e[M-1] ? ALPHA : ONE);
    assign w_p_step    = gf_mul(r_p, alpha_pow(GENSTART));
    assign o_dbg_state = r_state;

    always_comb begin
        w_n = M'(N);
        if (VARN != 0 && int'(bm_in_numn) >= CHECK + 1 && int'(bm_in_numn) <= N) w_n = bm_in_numn;
    end

    for (genvar g = 0; g <= T; g++) begin : g_lam
        localparam logic [M-1:0] A_G = alpha_pow(g);
        assign w_lam_step[g] = gf_mul(r_lam[g], A_G);
    end
    for (genvar g = 0; g < T; g++) begin : g_omg
        localparam logic [M-1:0] A_G = alpha_pow(g);
        assign w_omg_step[g] = gf_mul(r_omg[g], A_G);
    end

    always_comb begin
        w_l    = '0;
        w_lodd = '0;
        w_w    = '0;
        for (int i = 0; i <= T; i++) begin
            w_l = w_l ^ r_lam[i];
            if (i % 2 == 1) w_lodd = w_lodd ^ r_lam[i];
        end
        for (int j = 0; j < T; j++) w_w = w_w ^ r_omg[j];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bm_in_valid) w_next = S_PREP;
            S_PREP:   if (int'(r_pc) == P - 1) w_next = S_SEARCH;
            S_SEARCH: if (w_en && w_last) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // PREP: M square-and-multiply steps for b = alpha^(~(n-1)), then one b^c per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= T; i++) r_lam[i] <= '0;
            for (int j = 0; j < T; j++)  r_omg[j] <= '0;
            r_p    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_e    <= '0;
            r_n    <= '0;
            r_k    <= '0;
            r_pc   <= '0;
            r_ecnt <= '0;
            r_ch   <= '0;
        end else if (w_acc) begin
            for (int i = 0; i <= T; i++) r_lam[i] <= bm_in_error_locator[i*M +: M];
            for (int j = 0; j < T; j++)  r_omg[j] <= bm_in_error_evaluator[j*M +: M];
            r_ecnt <= bm_in_error_count;
            r_ch   <= bm_in_channel;
            r_n    <= w_n;
            r_e    <= ~(w_n - ONE);
            r_pc   <= '0;
            r_acc  <= ONE;
            r_p    <= (GENSTART == 0) ? ONE : '0;
            r_k    <= '0;
        end else if (r_state == S_PREP) begin
            r_pc <= r_pc + 1'b1;
            if (int'(r_pc) < M) begin
                r_acc <= w_sq;
                r_e   <= {r_e[M-2:0], 1'b0};
                if (int'(r_pc) == M - 1) r_b <= w_sq;
            end else begin
                r_acc <= gf_mul(r_acc, r_b);
                for (int i = 1; i <= T; i++)
                    if (int'(r_pc) == M - 1 + i) r_lam[i] <= gf_mul(r_lam[i], r_acc);
                for (int j = 1; j < T; j++)
                    if (int'(r_pc) == M - 1 + j) r_omg[j] <= gf_mul(r_omg[j], r_acc);
                if (int'(r_pc) == M - 1 + GENSTART) r_p <= r_acc;
            end
        end else if (r_state == S_SEARCH && w_en) begin
            for (int i = 0; i <= T; i++) r_lam[i] <= w_lam_step[i];
            for (int j = 0; j < T; j++)  r_omg[j] <= w_omg_step[j];
            r_p <= w_p_step;
            r_k <= r_k + ONE;
        end
    end

    assign w_err = r_s1_valid & (r_s1_l == '0);
    assign w_mag = w_err ? gf_mul(gf_mul(r_s1_p, r_s1_w), gf_inv(r_s1_lodd)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_s1_l     <= '0;
            r_s1_lodd  <= '0;
            r_s1_w     <= '0;
            r_s1_p     <= '0;
            r_s1_ecnt  <= '0;
            r_s1_ch    <= '0;
            r_o_valid  <= 1'b0;
            r_o_sop    <= 1'b0;
            r_o_eop    <= 1'b0;
            r_o_err    <= 1'b0;
            r_o_mag    <= '0;
            r_o_ecnt   <= '0;
            r_o_ch     <= '0;
        end else if (w_en) begin
            r_s1_valid <= (r_state == S_SEARCH);
            r_s1_sop   <= (r_state == S_SEARCH) && (r_k == '0);
            r_s1_eop   <= (r_state == S_SEARCH) && w_last;
            r_s1_l     <= w_l;
            r_s1_lodd  <= w_lodd;
            r_s1_w     <= w_w;
            r_s1_p     <= r_p;
            r_s1_ecnt  <= r_ecnt;
            r_s1_ch    <= r_ch;
            r_o_valid  <= r_s1_valid;
            r_o_sop    <= r_s1_valid & r_s1_sop;
            r_o_eop    <= r_s1_valid & r_s1_eop;
            r_o_err    <= w_err;
            r_o_mag    <= w_mag;
            r_o_ecnt   <= r_s1_valid ? r_s1_ecnt : '0;
            r_o_ch     <= r_s1_valid ? r_s1_ch : '0;
        end
    end

`ifdef RS_SEARCH_FAIL_CHECK_EN
    logic [M-1:0] r_errs;
    logic         r_o_fail;
    logic [M-1:0] w_tot;
    assign w_tot = (r_s1_sop ? '0 : r_errs) + {{(M-1){1'b0}}, w_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_errs   <= '0;
            r_o_fail <= 1'b0;
        end else if (w_en) begin
            r_o_fail <= r_s1_valid & r_s1_eop &
                        ((w_tot != M'(r_s1_ecnt)) | (int'(r_s1_ecnt) > T));
            if (r_s1_valid) r_errs <= w_tot;
        end
    end
    assign sch_out_fail = r_o_fail;
`else
    assign sch_out_fail = 1'b0;
`endif

    assign sch_out_valid           = r_o_valid;
    assign sch_out_sop             = r_o_sop;
    assign sch_out_eop             = r_o_eop;
    assign sch_out_error           = r_o_err;
    assign sch_out_error_magnitude = r_o_mag;
    assign sch_out_error_count     = r_o_ecnt;
    assign sch_out_channel         = r_o_ch;
endmodule
